// File: rtl/wb_eth_cmd_master.sv
// Ethernet register command to WISHBONE classic-cycle master bridge.
// One command in flight; every transaction bounded by a retry limit and a stb timeout.
module wb_eth_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic [7:0]              cmd_tag_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_dat_o,
    output logic [7:0]              resp_tag_o,
    output logic [1:0]              resp_status_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int unsigned TO_WIDTH  = 16;
    localparam int unsigned RTY_WIDTH = 4;
    localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_WIDTH-1:0] RTY_LIMIT = RTY_WIDTH'(RETRY_MAX);

    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RTY     = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_RESP
    } state_t;

    state_t                    r_state, w_state_next;
    logic                      r_cmd_ready, w_cmd_ready_next;
    logic                      r_cyc, w_cyc_next;
    logic                      r_resp_valid, w_resp_valid_next;
    logic                      r_we, w_we_next;
    logic [ADDR_WIDTH-1:0]     r_adr, w_adr_next;
    logic [DATA_WIDTH-1:0]     r_dat, w_dat_next;
    logic [DATA_WIDTH/8-1:0]   r_sel, w_sel_next;
    logic [7:0]                r_tag, w_tag_next;
    logic [DATA_WIDTH-1:0]     r_resp_dat, w_resp_dat_next;
    logic [1:0]                r_resp_status, w_resp_status_next;
    logic [RTY_WIDTH-1:0]      r_rty_cnt, w_rty_next;
    logic [TO_WIDTH-1:0]       r_to_cnt, w_to_next;

    // State and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_cyc         <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
            r_tag         <= '0;
            r_resp_dat    <= '0;
            r_resp_status <= '0;
            r_rty_cnt     <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cmd_ready   <= w_cmd_ready_next;
            r_cyc         <= w_cyc_next;
            r_resp_valid  <= w_resp_valid_next;
            r_we          <= w_we_next;
            r_adr         <= w_adr_next;
            r_dat         <= w_dat_next;
            r_sel         <= w_sel_next;
            r_tag         <= w_tag_next;
            r_resp_dat    <= w_resp_dat_next;
            r_resp_status <= w_resp_status_next;
            r_rty_cnt     <= w_rty_next;
            r_to_cnt      <= w_to_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_next       = r_state;
        w_we_next          = r_we;
        w_adr_next         = r_adr;
        w_dat_next         = r_dat;
        w_sel_next         = r_sel;
        w_tag_next         = r_tag;
        w_resp_dat_next    = r_resp_dat;
        w_resp_status_next = r_resp_status;
        w_rty_next         = r_rty_cnt;
        w_to_next          = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_we_next    = cmd_we_i;
                    w_adr_next   = cmd_adr_i;
                    w_dat_next   = cmd_dat_i;
                    w_sel_next   = cmd_sel_i;
                    w_tag_next   = cmd_tag_i;
                    w_rty_next   = '0;
                    w_to_next    = '0;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_to_next = r_to_cnt + TO_WIDTH'(1);
                // Terminations outrank a timeout expiring in the same cycle.
                if (wb_err_i) begin
                    w_resp_dat_next    = '0;
                    w_resp_status_next = ST_ERR;
                    w_state_next       = S_RESP;
                end else if (wb_ack_i) begin
                    w_resp_dat_next    = r_we ? '0 : wb_dat_i;
                    w_resp_status_next = ST_ACK;
                    w_state_next       = S_RESP;
                end else if (wb_rty_i) begin
                    if (r_rty_cnt < RTY_LIMIT) begin
                        w_rty_next   = r_rty_cnt + RTY_WIDTH'(1);
                        w_to_next    = '0;
                        w_state_next = S_GAP;
                    end else begin
                        w_resp_dat_next    = '0;
                        w_resp_status_next = ST_RTY;
                        w_state_next       = S_RESP;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_resp_dat_next    = '0;
                    w_resp_status_next = ST_TIMEOUT;
                    w_state_next       = S_RESP;
                end
            end
            S_GAP: begin
                w_state_next = S_ISSUE;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_cyc_next        = (w_state_next == S_ISSUE);
        w_cmd_ready_next  = (w_state_next == S_IDLE);
        w_resp_valid_next = (w_state_next == S_RESP);
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign resp_valid_o  = r_resp_valid;
    assign resp_dat_o    = r_resp_dat;
    assign resp_tag_o    = r_tag;
    assign resp_status_o = r_resp_status;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_cyc;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_dat_o      = r_dat;
    assign wb_sel_o      = r_sel;

endmodule

// File: tb/tb_wb_eth_cmd_master.sv
// Bench for wb_eth_cmd_master: scripted WISHBONE slave plus a per-command
// outcome model (status, data, stb cycles, gaps, latency).
module tb_wb_eth_cmd_master;

    localparam int TO = 16;
    localparam int RM = 3;

    localparam int T_NONE   = 0;
    localparam int T_ACK    = 1;
    localparam int T_ERR    = 2;
    localparam int T_RTY    = 3;
    localparam int T_ERRACK = 4;
    localparam int T_ACKRTY = 5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [27:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [7:0]  cmd_tag_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_dat_o;
    logic [7:0]  resp_tag_o;
    logic [1:0]  resp_status_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [27:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Slave script: per attempt, wait cycles before termination and termination kind.
    int          att_wait [8];
    int          att_term [8];
    logic [31:0] att_rdata[8];

    wb_eth_cmd_master #(
        .ADDR_WIDTH(28), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .RETRY_MAX(RM)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .cmd_sel_i(cmd_sel_i), .cmd_tag_i(cmd_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_dat_o(resp_dat_o), .resp_tag_o(resp_tag_o), .resp_status_o(resp_status_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_att(input int a, input int w, input int t);
        att_wait[a]  = w;
        att_term[a]  = t;
        att_rdata[a] = $urandom;
    endtask

    task automatic clear_script();
        for (int a = 0; a < 8; a++) set_att(a, 0, T_NONE);
    endtask

    task automatic quiet_slave();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
    endtask

    // Random terminations in cycles where the master has no stb up.
    task automatic noise();
        wb_ack_i = 1'($urandom_range(0, 1));
        wb_err_i = 1'($urandom_range(0, 1));
        wb_rty_i = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom;
    endtask

    task automatic drive_terms(input int a, input int bc);
        bit hit;
        int t;
        hit = (a < 8) && (bc == att_wait[a]) && (att_term[a] != T_NONE);
        t   = (a < 8) ? att_term[a] : T_NONE;
        wb_ack_i = hit && (t == T_ACK || t == T_ERRACK || t == T_ACKRTY);
        wb_err_i = hit && (t == T_ERR || t == T_ERRACK);
        wb_rty_i = hit && (t == T_RTY || t == T_ACKRTY);
        wb_dat_i = (hit && a < 8) ? att_rdata[a] : $urandom;
    endtask

    // Outcome of one command from the slave script, walking attempts.
    function automatic void model(input logic we, output logic [1:0] st, output logic [31:0] d,
                                  output int stb, output int gaps, output int bursts);
        int t;
        int w;
        st = 2'b00; d = '0; stb = 0; gaps = 0; bursts = 0;
        for (int a = 0; a <= RM; a++) begin
            t = att_term[a];
            w = att_wait[a];
            bursts++;
            if (t == T_NONE || w >= TO) begin
                stb += TO; st = 2'b11; return;
            end
            stb += w + 1;
            if (t == T_ERR || t == T_ERRACK) begin
                st = 2'b01; return;
            end
            if (t == T_ACK || t == T_ACKRTY) begin
                st = 2'b00; d = we ? 32'h0 : att_rdata[a]; return;
            end
            if (a == RM) begin
                st = 2'b10; return;
            end
            gaps++;
        end
    endfunction

    task automatic accept_cmd(input logic we, input logic [27:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [7:0] tag);
        int n;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_tag_i = tag;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = 4'($urandom);
        chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
    endtask

    task automatic run_cmd(input logic we, input logic [27:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [7:0] tag, input int rdy_delay);
        logic [1:0]  e_st;
        logic [31:0] e_dat;
        int e_stb, e_gaps, e_bursts;
        int stb_cnt, gap_cnt, bursts, att, bc, lat;
        bit stable_ok, prev_stb;
        logic [44:0] snap;
        stb_cnt = 0; gap_cnt = 0; bursts = 0; att = 0; bc = 0; lat = 0;
        stable_ok = 1'b1; prev_stb = 1'b0;
        model(we, e_st, e_dat, e_stb, e_gaps, e_bursts);
        accept_cmd(we, adr, dat, sel, tag);
        for (int k = 1; k <= 400; k++) begin
            if (resp_valid_o) begin
                lat = k;
                break;
            end
            if (wb_cyc_o !== wb_stb_o) stable_ok = 1'b0;
            if (wb_stb_o) begin
                stb_cnt++;
                if (!prev_stb) bursts++;
                if (wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== sel || wb_we_o !== we)
                    stable_ok = 1'b0;
                drive_terms(att, bc);
                bc++;
            end else begin
                gap_cnt++;
                if (prev_stb) begin
                    att++;
                    bc = 0;
                end
                noise();
            end
            prev_stb = wb_stb_o;
            @(negedge clk_i);
        end
        quiet_slave();
        chk("latency", 64'(lat), 64'(e_stb + e_gaps + 1));
        chk("stb_cycles", 64'(stb_cnt), 64'(e_stb));
        chk("gap_cycles", 64'(gap_cnt), 64'(e_gaps));
        chk("stb_bursts", 64'(bursts), 64'(e_bursts));
        chk("wb_stable", 64'(stable_ok), 64'd1);
        chk("cyc_in_resp", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        chk("resp_status", 64'(resp_status_o), 64'(e_st));
        chk("resp_dat", 64'(resp_dat_o), 64'(e_dat));
        chk("resp_tag", 64'(resp_tag_o), 64'(tag));
        snap = {1'b1, e_dat, tag, e_st, 1'b0, 1'b0};
        for (int i = 0; i < rdy_delay; i++) begin
            noise();
            @(negedge clk_i);
            chk("resp_hold", 64'({resp_valid_o, resp_dat_o, resp_tag_o, resp_status_o,
                                  cmd_ready_o, wb_cyc_o}), 64'(snap));
        end
        quiet_slave();
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk("post_handshake", 64'({resp_valid_o, cmd_ready_o, wb_cyc_o}), 64'b010);
    endtask

    initial begin
        int n_ok;
        bit clean;
        logic [31:0] pick;
        clear_script();
        quiet_slave();
        repeat (3) @(negedge clk_i);
        chk("reset_wb", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o}), 64'd0);
        chk("reset_wbdat", 64'(wb_dat_o), 64'd0);
        chk("reset_resp", 64'({resp_valid_o, resp_dat_o, resp_tag_o, resp_status_o}), 64'd0);
        chk("reset_ready", 64'(cmd_ready_o), 64'd1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_reset", 64'(cmd_ready_o), 64'd1);

        // Read, zero-wait.
        clear_script(); set_att(0, 0, T_ACK); att_rdata[0] = 32'hDEADBEEF;
        run_cmd(1'b0, 28'h0004010, 32'h0, 4'hF, 8'h5A, 0);
        // Write, three wait states.
        clear_script(); set_att(0, 3, T_ACK);
        run_cmd(1'b1, 28'h8000100, 32'h12345678, 4'hF, 8'h11, 1);
        // Two retries, then ack.
        clear_script(); set_att(0, 0, T_RTY); set_att(1, 1, T_RTY); set_att(2, 2, T_ACK);
        run_cmd(1'b0, 28'h0000200, 32'h0, 4'h3, 8'h22, 0);
        // Retry on every attempt exhausts the limit.
        clear_script();
        for (int a = 0; a < 8; a++) set_att(a, a, T_RTY);
        run_cmd(1'b0, 28'h0000300, 32'h0, 4'hF, 8'h33, 0);
        // Silent slave times out; ack in the last allowed cycle still completes.
        clear_script();
        run_cmd(1'b1, 28'h0000400, 32'hCAFEF00D, 4'hC, 8'h44, 0);
        clear_script(); set_att(0, TO - 1, T_ACK);
        run_cmd(1'b0, 28'h0000500, 32'h0, 4'hF, 8'h55, 0);
        // Response backpressure.
        clear_script(); set_att(0, 1, T_ACK);
        run_cmd(1'b0, 28'h0000600, 32'h0, 4'hF, 8'h66, 10);
        // Termination priority.
        clear_script(); set_att(0, 2, T_ERRACK);
        run_cmd(1'b0, 28'h0000700, 32'h0, 4'hF, 8'h77, 0);
        clear_script(); set_att(0, 0, T_ACKRTY);
        run_cmd(1'b0, 28'h0000800, 32'h0, 4'hF, 8'h88, 0);

        // Reset in the third stb cycle aborts without a response.
        clear_script();
        accept_cmd(1'b0, 28'h0000900, 32'h0, 4'hF, 8'h99);
        n_ok = 0;
        for (int k = 0; k < 3; k++) begin
            if (wb_stb_o) n_ok++;
            if (k < 2) @(negedge clk_i);
        end
        chk("stb_before_reset", 64'(n_ok), 64'd3);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_state", 64'({wb_cyc_o, wb_stb_o, resp_valid_o, cmd_ready_o}), 64'b0001);
        clean = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (resp_valid_o || wb_cyc_o) clean = 1'b0;
        end
        chk("no_resp_after_abort", 64'(clean), 64'd1);
        clear_script(); set_att(0, 0, T_ACK);
        run_cmd(1'b0, 28'h0000A00, 32'h0, 4'hF, 8'hAA, 0);

        // Randomised commands against the outcome model.
        for (int i = 0; i < 40; i++) begin
            for (int a = 0; a < 8; a++) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0:          att_term[a] = T_NONE;
                    1, 2, 3:    att_term[a] = T_ACK;
                    4:          att_term[a] = T_ERR;
                    5, 6, 7:    att_term[a] = T_RTY;
                    8:          att_term[a] = T_ERRACK;
                    default:    att_term[a] = T_ACKRTY;
                endcase
                att_wait[a]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 18))
                                                           : int'($urandom_range(0, 4));
                att_rdata[a] = $urandom;
            end
            run_cmd(1'($urandom_range(0, 1)), 28'($urandom), $urandom, 4'($urandom),
                    8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
